// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq
// Reset sequencer for a PLL's RST/LOCK interface. It drives the PLL reset and
// synchronizes the PLL lock. Once lock has been stable long enough, it releases
// the system reset for logic on the PLL output clocks. On a lock loss or a lock
// timeout it pulses the PLL reset again and retries. After MAX_RETRY
// consecutive timeouts it latches a fault.
//
// Ports:
//   clk        - free-running reference clock (also the PLL input clock)
//   rst        - asynchronous active-high reset
//   pll_lock   - PLL lock, asynchronous to clk
//   pll_rst    - PLL reset, active-high
//   sys_rst    - downstream system reset, active-high, low only in RUN
//   pll_ok     - high only in RUN
//   fail       - latched fault, high only in FAIL
//   relock_cnt - saturating count of lock losses seen while in RUN
//   state_dbg  - current state code (0..4)
// -----------------------------------------------------------------------------
module pll_rst_seq #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 50000,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRY     = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_lock,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             pll_ok,
   output logic             fail,
   output logic [CNT_W-1:0] relock_cnt,
   output logic [2:0]       state_dbg
);

   localparam int unsigned TMR_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned TMR_MAX  = (TMR_MAX0 > STABLE_CYCLES) ? TMR_MAX0 : STABLE_CYCLES;
   localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      StPllRst    = 3'd0,
      StWaitLock  = 3'd1,
      StStableChk = 3'd2,
      StRun       = 3'd3,
      StFail      = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [TMR_W-1:0]   r_timer;
   logic [TMR_W-1:0]   w_timer_nxt;
   logic [3:0]         r_retry;
   logic [3:0]         w_retry_nxt;
   logic [3:0]         w_retry_inc;
   logic [CNT_W-1:0]   r_relock_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_sync1;
   logic               r_lock_s;
   logic               r_pll_rst;
   logic               r_sys_rst;
   logic               r_pll_ok;
   logic               r_fail;

   assign w_retry_inc = r_retry + 4'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_retry_nxt = r_retry;
      w_cnt_nxt   = r_relock_cnt;
      unique case (r_state)
         StPllRst: begin
            if (r_timer == TMR_W'(RST_CYCLES - 1)) w_state_nxt = StWaitLock;
         end
         StWaitLock: begin
            // Lock takes priority over a timeout on the same cycle.
            if (r_lock_s) begin
               w_state_nxt = StStableChk;
            end else if (r_timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
               w_retry_nxt = w_retry_inc;
               w_state_nxt = (w_retry_inc == 4'(MAX_RETRY)) ? StFail : StPllRst;
            end
         end
         StStableChk: begin
            // A drop during qualification restarts the wait; it is not a retry.
            if (!r_lock_s) begin
               w_state_nxt = StWaitLock;
            end else if (r_timer == TMR_W'(STABLE_CYCLES - 1)) begin
               w_state_nxt = StRun;
               w_retry_nxt = 4'd0;
            end
         end
         StRun: begin
            if (!r_lock_s) begin
               w_state_nxt = StPllRst;
               if (r_relock_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_relock_cnt + CNT_W'(1);
            end
         end
         StFail: begin
            w_state_nxt = StFail;
         end
         default: begin
            w_state_nxt = StPllRst;
         end
      endcase

      // The timer is unused in RUN and FAIL, so it is held there.
      if (w_state_nxt != r_state) begin
         w_timer_nxt = '0;
      end else if (r_state == StRun || r_state == StFail) begin
         w_timer_nxt = r_timer;
      end else begin
         w_timer_nxt = r_timer + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1      <= 1'b0;
         r_lock_s     <= 1'b0;
         r_state      <= StPllRst;
         r_timer      <= '0;
         r_retry      <= 4'd0;
         r_relock_cnt <= '0;
         r_pll_rst    <= 1'b1;
         r_sys_rst    <= 1'b1;
         r_pll_ok     <= 1'b0;
         r_fail       <= 1'b0;
      end else begin
         r_sync1      <= pll_lock;
         r_lock_s     <= r_sync1;
         r_state      <= w_state_nxt;
         r_timer      <= w_timer_nxt;
         r_retry      <= w_retry_nxt;
         r_relock_cnt <= w_cnt_nxt;
         // Outputs decode the next state so they change with the state register.
         r_pll_rst    <= (w_state_nxt == StPllRst) || (w_state_nxt == StFail);
         r_sys_rst    <= (w_state_nxt != StRun);
         r_pll_ok     <= (w_state_nxt == StRun);
         r_fail       <= (w_state_nxt == StFail);
      end
   end

   assign pll_rst    = r_pll_rst;
   assign sys_rst    = r_sys_rst;
   assign pll_ok     = r_pll_ok;
   assign fail       = r_fail;
   assign relock_cnt = r_relock_cnt;
   assign state_dbg  = r_state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_seq
// Directed bench for pll_rst_seq with RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, MAX_RETRY=3, CNT_W=2. Outputs are sampled 1 time unit after
// each rising clock edge; cyc counts edges since the last rst release.
// -----------------------------------------------------------------------------
module tb_pll_rst_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_lock = 1'b0;
   logic       pll_rst;
   logic       sys_rst;
   logic       pll_ok;
   logic       fail;
   logic [1:0] relock_cnt;
   logic [2:0] state_dbg;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   pll_rst_seq #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (32),
      .STABLE_CYCLES(8),
      .MAX_RETRY    (3),
      .CNT_W        (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pll_lock  (pll_lock),
      .pll_rst   (pll_rst),
      .sys_rst   (sys_rst),
      .pll_ok    (pll_ok),
      .fail      (fail),
      .relock_cnt(relock_cnt),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick_to(input int n);
      while (cyc < n) tick();
   endtask

   // Assert rst for one edge, release it just after an edge; cyc restarts at 0.
   task automatic do_reset();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   // Reset, wait 5 cycles into WAIT_LOCK, raise lock; RUN is reached at cyc 20.
   task automatic bring_up();
      pll_lock = 1'b0;
      do_reset();
      tick_to(9);
      pll_lock = 1'b1;
      tick_to(20);
      checks++;
      if (state_dbg !== 3'd3) begin
         failures++;
         $display("FAIL bring_up_run: state_dbg=%0d expected 3", state_dbg);
      end
   endtask

   // Drop lock in RUN, check the 3-edge response, relock and check RUN return.
   task automatic lose_relock(input int exp_cnt);
      pll_lock = 1'b0;
      cyc = 0;
      tick_to(2);
      checks++;
      if (sys_rst !== 1'b0 || pll_rst !== 1'b0) begin
         failures++;
         $display("FAIL loss_edge2: sys_rst=%0b pll_rst=%0b expected 0 0", sys_rst, pll_rst);
      end
      tick_to(3);
      checks++;
      if (sys_rst !== 1'b1 || pll_rst !== 1'b1 || state_dbg !== 3'd0) begin
         failures++;
         $display("FAIL loss_edge3: sys_rst=%0b pll_rst=%0b state=%0d expected 1 1 0",
                  sys_rst, pll_rst, state_dbg);
      end
      checks++;
      if (relock_cnt !== 2'(exp_cnt)) begin
         failures++;
         $display("FAIL relock_cnt: got %0d expected %0d", relock_cnt, exp_cnt);
      end
      pll_lock = 1'b1;
      tick_to(15);
      checks++;
      if (state_dbg !== 3'd2 || sys_rst !== 1'b1) begin
         failures++;
         $display("FAIL relock_pre: state=%0d sys_rst=%0b expected 2 1", state_dbg, sys_rst);
      end
      tick_to(16);
      checks++;
      if (state_dbg !== 3'd3 || sys_rst !== 1'b0 || pll_ok !== 1'b1) begin
         failures++;
         $display("FAIL relock_run: state=%0d sys_rst=%0b pll_ok=%0b expected 3 0 1",
                  state_dbg, sys_rst, pll_ok);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pll_lock = 1'b0;
      tick();
      tick();
      checks++;
      if ({pll_rst, sys_rst, pll_ok, fail} !== 4'b1100 || relock_cnt !== 2'd0 ||
          state_dbg !== 3'd0) begin
         failures++;
         $display("FAIL reset_values: rst/sys/ok/fail=%b cnt=%0d state=%0d expected 1100 0 0",
                  {pll_rst, sys_rst, pll_ok, fail}, relock_cnt, state_dbg);
      end
   endtask

   task automatic test_bringup();
      pll_lock = 1'b0;
      do_reset();
      for (int n = 1; n <= 4; n++) begin
         tick_to(n);
         checks++;
         if (pll_rst !== (n < 4)) begin
            failures++;
            $display("FAIL bringup_pll_rst@%0d: got %0b expected %0b", n, pll_rst, n < 4);
         end
      end
      checks++;
      if (state_dbg !== 3'd1) begin
         failures++;
         $display("FAIL bringup_wait: state=%0d expected 1", state_dbg);
      end
      tick_to(9);
      pll_lock = 1'b1;
      tick_to(19);
      checks++;
      if (sys_rst !== 1'b1 || state_dbg !== 3'd2) begin
         failures++;
         $display("FAIL bringup_edge10: sys_rst=%0b state=%0d expected 1 2", sys_rst, state_dbg);
      end
      tick_to(20);
      checks++;
      if (sys_rst !== 1'b0 || pll_ok !== 1'b1 || relock_cnt !== 2'd0 || pll_rst !== 1'b0) begin
         failures++;
         $display("FAIL bringup_edge11: sys=%0b ok=%0b cnt=%0d prst=%0b expected 0 1 0 0",
                  sys_rst, pll_ok, relock_cnt, pll_rst);
      end
   endtask

   task automatic test_chatter();
      logic saw_prst;
      saw_prst = 1'b0;
      pll_lock = 1'b0;
      do_reset();
      tick_to(4);
      cyc = 0;
      pll_lock = 1'b1;
      tick_to(5);
      pll_lock = 1'b0;
      tick_to(7);
      pll_lock = 1'b1;
      while (cyc < 18) begin
         tick();
         if (pll_rst) saw_prst = 1'b1;
         if (cyc == 8) begin
            checks++;
            if (state_dbg !== 3'd1) begin
               failures++;
               $display("FAIL chatter_back_to_wait: state=%0d expected 1", state_dbg);
            end
         end
         if (cyc == 17) begin
            checks++;
            if (sys_rst !== 1'b1) begin
               failures++;
               $display("FAIL chatter_edge10: sys_rst=%0b expected 1", sys_rst);
            end
         end
      end
      checks++;
      if (sys_rst !== 1'b0 || state_dbg !== 3'd3) begin
         failures++;
         $display("FAIL chatter_edge11: sys_rst=%0b state=%0d expected 0 3", sys_rst, state_dbg);
      end
      checks++;
      if (saw_prst !== 1'b0) begin
         failures++;
         $display("FAIL chatter_no_pll_rst: saw pll_rst=%0b expected 0", saw_prst);
      end
   endtask

   task automatic test_lock_loss();
      bring_up();
      for (int i = 1; i <= 4; i++) lose_relock((i > 3) ? 3 : i);
   endtask

   task automatic test_timeout();
      logic exp;
      pll_lock = 1'b0;
      do_reset();
      tick_to(4);
      for (int n = 5; n <= 108; n++) begin
         tick_to(n);
         exp = (n >= 36 && n <= 39) || (n >= 72 && n <= 75) || (n >= 108);
         checks++;
         if (pll_rst !== exp) begin
            failures++;
            $display("FAIL timeout_pll_rst@%0d: got %0b expected %0b", n, pll_rst, exp);
         end
      end
      checks++;
      if (state_dbg !== 3'd4 || fail !== 1'b1 || sys_rst !== 1'b1) begin
         failures++;
         $display("FAIL timeout_fail: state=%0d fail=%0b sys_rst=%0b expected 4 1 1",
                  state_dbg, fail, sys_rst);
      end
      pll_lock = 1'b1;
      tick_to(128);
      checks++;
      if (state_dbg !== 3'd4 || fail !== 1'b1 || pll_rst !== 1'b1 || pll_ok !== 1'b0) begin
         failures++;
         $display("FAIL fail_absorbing: state=%0d fail=%0b prst=%0b ok=%0b expected 4 1 1 0",
                  state_dbg, fail, pll_rst, pll_ok);
      end
   endtask

   task automatic test_coincidence();
      pll_lock = 1'b0;
      do_reset();
      tick_to(40);
      checks++;
      if (state_dbg !== 3'd1 || pll_rst !== 1'b0) begin
         failures++;
         $display("FAIL coin_first_retry: state=%0d prst=%0b expected 1 0", state_dbg, pll_rst);
      end
      tick_to(69);
      pll_lock = 1'b1;
      tick_to(71);
      checks++;
      if (state_dbg !== 3'd1) begin
         failures++;
         $display("FAIL coin_pre: state=%0d expected 1", state_dbg);
      end
      tick_to(72);
      checks++;
      if (state_dbg !== 3'd2 || pll_rst !== 1'b0) begin
         failures++;
         $display("FAIL coin_lock_wins: state=%0d prst=%0b expected 2 0", state_dbg, pll_rst);
      end
      pll_lock = 1'b0;
      tick_to(75);
      checks++;
      if (state_dbg !== 3'd1 || pll_rst !== 1'b0) begin
         failures++;
         $display("FAIL coin_drop_to_wait: state=%0d prst=%0b expected 1 0", state_dbg, pll_rst);
      end
      // retry must still be 1: this timeout makes it 2, not MAX_RETRY.
      tick_to(107);
      checks++;
      if (state_dbg !== 3'd0 || fail !== 1'b0 || pll_rst !== 1'b1) begin
         failures++;
         $display("FAIL coin_retry_kept: state=%0d fail=%0b prst=%0b expected 0 0 1",
                  state_dbg, fail, pll_rst);
      end
   endtask

   task automatic test_async_reset();
      bring_up();
      lose_relock(1);
      lose_relock(2);
      tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({pll_rst, sys_rst, pll_ok, fail} !== 4'b1100 || relock_cnt !== 2'd0 ||
          state_dbg !== 3'd0) begin
         failures++;
         $display("FAIL async_reset: rst/sys/ok/fail=%b cnt=%0d state=%0d expected 1100 0 0",
                  {pll_rst, sys_rst, pll_ok, fail}, relock_cnt, state_dbg);
      end
      #1;
      rst = 1'b0;
      cyc = 0;
      tick_to(3);
      checks++;
      if (pll_rst !== 1'b1 || state_dbg !== 3'd0) begin
         failures++;
         $display("FAIL async_restart_rst: prst=%0b state=%0d expected 1 0", pll_rst, state_dbg);
      end
      tick_to(4);
      checks++;
      if (pll_rst !== 1'b0 || state_dbg !== 3'd1) begin
         failures++;
         $display("FAIL async_restart_wait: prst=%0b state=%0d expected 0 1", pll_rst, state_dbg);
      end
      tick_to(13);
      checks++;
      if (state_dbg !== 3'd3 || sys_rst !== 1'b0 || relock_cnt !== 2'd0) begin
         failures++;
         $display("FAIL async_restart_run: state=%0d sys=%0b cnt=%0d expected 3 0 0",
                  state_dbg, sys_rst, relock_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_chatter();
      test_lock_loss();
      test_timeout();
      test_coincidence();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
